// File: rtl/lwe_dec.sv
// LWE decryption: m = decode(c0 + c1*s) over Z_p[x]/(x^N+1), one serial MAC per cycle.
// Latency: N*N+1 edges from the final captured coefficient to msg_ready.
// Streams are sampled on their ready strobes in LOAD only; no backpressure, surplus coefficients dropped.
module lwe_dec #(
   parameter int p    = 17,
   parameter int logP = 5,
   parameter int N    = 8,
   parameter int logN = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            cipher_ready,
   input  logic [logP-1:0] cipher_c0,
   input  logic [logP-1:0] cipher_c1,
   input  logic            key_ready,
   input  logic [logP-1:0] sec_key,
   output logic [N-1:0]    message,
   output logic            msg_ready,
   output logic            busy
);

   localparam logic [logN:0]      N_CNT = (logN+1)'(N);
   localparam logic [logN-1:0]    LAST  = (logN)'(N-1);
   localparam logic [logP:0]      P_A   = (logP+1)'(p);
   localparam logic [2*logP-1:0]  P_W   = (2*logP)'(p);
   localparam logic [logP-1:0]    LO    = (logP)'(p/4);
   localparam logic [logP-1:0]    HI    = (logP)'((3*p)/4);

   typedef enum logic [2:0] {IDLE, LOAD, MULT, DECODE, DONE} state_t;

   state_t            state, state_nx;
   logic [logN:0]     ct_cnt, sk_cnt, ct_nx, sk_nx;
   logic [logN-1:0]   ct_idx, sk_idx, i_idx, j_idx, tgt;
   logic              cap_ct, cap_sk, load_fin, last_mac, start_ok, wrap;
   logic [logP-1:0]   c0  [N];
   logic [logP-1:0]   c1  [N];
   logic [logP-1:0]   s   [N];
   logic [logP-1:0]   acc [N];
   logic [2*logP-1:0] prod;
   logic [logP-1:0]   prod_mod, acc_t, mac_res;
   logic [logP:0]     ij, sum;
   logic [N-1:0]      dec;

   // Stream capture qualifiers and the "both streams complete this edge" condition
   always_comb begin
      cap_ct   = (state == LOAD) && cipher_ready && (ct_cnt < N_CNT);
      cap_sk   = (state == LOAD) && key_ready && (sk_cnt < N_CNT);
      ct_nx    = ct_cnt + (logN+1)'(cap_ct);
      sk_nx    = sk_cnt + (logN+1)'(cap_sk);
      ct_idx   = ct_cnt[logN-1:0];
      sk_idx   = sk_cnt[logN-1:0];
      load_fin = (state == LOAD) && (ct_nx == N_CNT) && (sk_nx == N_CNT);
      last_mac = (state == MULT) && (i_idx == LAST) && (j_idx == LAST);
      start_ok = start && ((state == IDLE) || (state == DONE));
   end

   // One negacyclic multiply-accumulate step: acc[(i+j) mod N] +/- c1[i]*s[j] mod p
   always_comb begin
      ij       = {1'b0, i_idx} + {1'b0, j_idx};
      wrap     = (ij >= N_CNT);
      tgt      = wrap ? (logN)'(ij - N_CNT) : ij[logN-1:0];
      prod     = {{logP{1'b0}}, c1[i_idx]} * {{logP{1'b0}}, s[j_idx]};
      prod_mod = (logP)'(prod % P_W);
      acc_t    = acc[tgt];
      sum      = {1'b0, acc_t} + {1'b0, prod_mod};
      mac_res  = '0;
      if (wrap) begin
         // borrow: fold back into range by adding p before subtracting
         if (acc_t < prod_mod)
            mac_res = (logP)'({1'b0, acc_t} + P_A - {1'b0, prod_mod});
         else
            mac_res = acc_t - prod_mod;
      end else begin
         mac_res = (sum >= P_A) ? (logP)'(sum - P_A) : sum[logP-1:0];
      end
   end

   // Threshold decode: a coefficient near p/2 carries a one
   always_comb begin
      dec = '0;
      for (int k = 0; k < N; k++)
         dec[k] = (acc[k] > LO) && (acc[k] <= HI);
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (load_fin) state_nx = MULT;
         MULT:    if (last_mac) state_nx = DECODE;
         DECODE:  state_nx = DONE;
         DONE:    if (start) state_nx = LOAD;
         default: state_nx = IDLE;
      endcase
   end

   // State register, load counters, MAC indices and the decoded message
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ct_cnt  <= '0;
         sk_cnt  <= '0;
         i_idx   <= '0;
         j_idx   <= '0;
         message <= '0;
      end else begin
         state <= state_nx;
         if (start_ok) begin
            ct_cnt <= '0;
            sk_cnt <= '0;
            i_idx  <= '0;
            j_idx  <= '0;
         end
         if (state == LOAD) begin
            ct_cnt <= ct_nx;
            sk_cnt <= sk_nx;
            i_idx  <= '0;
            j_idx  <= '0;
         end
         if (state == MULT) begin
            if (j_idx == LAST) begin
               j_idx <= '0;
               i_idx <= (i_idx == LAST) ? '0 : i_idx + 1'b1;
            end else begin
               j_idx <= j_idx + 1'b1;
            end
         end
         if (state == DECODE)
            message <= dec;
      end
   end

   // Coefficient storage and accumulator; acc is seeded from c0 with the
   // coefficient arriving on the same edge forwarded so MULT starts immediately
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == LOAD) begin
            if (cap_ct) begin
               c0[ct_idx] <= cipher_c0;
               c1[ct_idx] <= cipher_c1;
            end
            if (cap_sk)
               s[sk_idx] <= sec_key;
            if (load_fin) begin
               for (int k = 0; k < N; k++)
                  acc[k] <= (cap_ct && (ct_idx == (logN)'(k))) ? cipher_c0 : c0[k];
            end
         end else if (state == MULT) begin
            acc[tgt] <= mac_res;
         end
      end
   end

   assign msg_ready = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lwe_dec.sv
// Directed bench for lwe_dec: a polynomial-level model supplies the expected
// message and completion cycle, a per-cycle monitor compares the DUT outputs,
// and literal values pin the model on the hand-worked vectors.
module tb_lwe_dec;
   localparam int P    = 17;
   localparam int LOGP = 5;
   localparam int NN   = 8;
   localparam int LOGN = 3;

   logic            clk = 0, reset = 0, start = 0, cipher_ready = 0, key_ready = 0;
   logic [LOGP-1:0] cipher_c0 = 0, cipher_c1 = 0, sec_key = 0;
   logic [NN-1:0]   message;
   logic            msg_ready, busy;

   lwe_dec #(.p(P), .logP(LOGP), .N(NN), .logN(LOGN)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cipher_ready(cipher_ready), .cipher_c0(cipher_c0), .cipher_c1(cipher_c1),
      .key_ready(key_ready), .sec_key(sec_key),
      .message(message), .msg_ready(msg_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int            errors = 0, n_chk = 0, cyc = 0, done_cyc = 0, last_cap = 0, lat = 0;
   bit            chk_en = 0, run_valid = 0, exp_busy = 0;
   logic [NN-1:0] cur_msg = '0, held_msg = '0, exp_msg = '0;
   int            tc0 [NN], tc1 [NN], ts [NN], m_acc [NN];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Negacyclic product summed in plain integers, reduced once at the end
   function automatic logic [NN-1:0] model();
      int a [NN];
      logic [NN-1:0] m;
      for (int k = 0; k < NN; k++) a[k] = tc0[k];
      for (int i = 0; i < NN; i++)
         for (int j = 0; j < NN; j++)
            if (i + j < NN) a[i+j] += tc1[i] * ts[j];
            else            a[i+j-NN] -= tc1[i] * ts[j];
      m = '0;
      for (int k = 0; k < NN; k++) begin
         a[k] = ((a[k] % P) + P) % P;
         m_acc[k] = a[k];
         m[k] = (a[k] > P/4) && (a[k] <= (3*P)/4);
      end
      return m;
   endfunction

   // Per-cycle monitor against the bench's expectation of ready/message/busy
   always @(negedge clk) begin
      bit er;
      if (chk_en) begin
         er = run_valid && (cyc >= done_cyc);
         chk("mon_msg_ready", 32'(msg_ready), 32'(er));
         chk("mon_message", 32'(message), 32'(er ? cur_msg : held_msg));
         chk("mon_busy", 32'(busy), 32'(exp_busy));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1;
      tick;
      run_valid = 0; held_msg = '0; cur_msg = '0; exp_busy = 0;
      reset = 0;
   endtask

   task automatic do_start;
      if (run_valid) held_msg = cur_msg;
      start = 1;
      tick;
      start = 0;
      run_valid = 0;
      exp_busy = 1;
   endtask

   // Drive both streams; key_first holds off the ciphertext until the key
   // (including extras) is sent, gap inserts idle cycles between ct beats
   task automatic stream(input bit key_first, input int gap, input int extra);
      int kp, cp, gc;
      bit kv, cv, fin;
      kp = 0; cp = 0; gc = 0; fin = 0;
      for (int it = 0; it < 300; it++) begin
         if (kp >= NN + extra && cp >= NN + extra) break;
         kv = (kp < NN + extra);
         cv = (cp < NN + extra) && (!key_first || kp >= NN + extra) && (gc == 0);
         key_ready    = kv;
         sec_key      = LOGP'(kp < NN ? ts[kp] : kp * 7 + 3);
         cipher_ready = cv;
         cipher_c0    = LOGP'(cp < NN ? tc0[cp] : cp * 5 + 1);
         cipher_c1    = LOGP'(cp < NN ? tc1[cp] : cp * 3 + 2);
         tick;
         if (kv) kp++;
         if (cv) begin cp++; gc = gap; end
         else if (gc > 0) gc--;
         if (!fin && kp >= NN && cp >= NN) begin
            fin = 1;
            last_cap = cyc;
            done_cyc = cyc + 65;
            cur_msg = model();
            run_valid = 1;
         end
      end
      key_ready = 0; cipher_ready = 0;
   endtask

   task automatic wait_done(output int l);
      for (int t = 0; t < 120; t++) begin
         if (msg_ready === 1'b1) break;
         tick;
      end
      chk("done_reached", 32'(msg_ready), 1);
      l = cyc - last_cap;
      tick;
   endtask

   task automatic set_identity;
      tc0 = '{8, 0, 8, 0, 16, 12, 5, 4};
      tc1 = '{3, 1, 4, 1, 5, 9, 2, 6};
      ts  = '{default: 0};
   endtask

   task automatic set_pattern;
      for (int k = 0; k < NN; k++) begin
         tc0[k] = (3*k + 1) % P;
         tc1[k] = (5*k + 2) % P;
         ts[k]  = (7*k + 3) % P;
      end
   endtask

   initial begin
      do_reset;
      chk_en = 1;
      tick;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_msg_ready", 32'(msg_ready), 0);
      chk("rst_message", 32'(message), 0);

      // identity key: message is the threshold of c0
      set_identity;
      chk("model_identity", 32'(model()), 32'h65);
      do_start;
      chk("start_busy", 32'(busy), 1);
      stream(0, 0, 0);
      wait_done(lat);
      chk("id_message", 32'(message), 32'h65);
      chk("id_latency", lat, 65);

      // plain product, started from DONE
      tc0 = '{default: 0}; tc1 = '{default: 0}; ts = '{default: 0};
      tc1[1] = 2; ts[2] = 3;
      chk("model_plain", 32'(model()), 32'h08);
      chk("model_plain_acc3", m_acc[3], 6);
      do_start;
      chk("done_start_msg_ready", 32'(msg_ready), 0);
      chk("done_start_busy", 32'(busy), 1);
      stream(0, 0, 0);
      wait_done(lat);
      chk("plain_message", 32'(message), 32'h08);

      // negacyclic wrap
      tc1 = '{default: 0}; ts = '{default: 0};
      tc1[7] = 1; ts[1] = 8;
      chk("model_wrap", 32'(model()), 32'h01);
      chk("model_wrap_acc0", m_acc[0], 9);
      do_start;
      stream(0, 0, 0);
      wait_done(lat);
      chk("wrap_message", 32'(message), 32'h01);

      // general pattern, gap-free then key-first with gaps and extras
      set_pattern;
      exp_msg = model();
      do_start;
      stream(0, 0, 0);
      wait_done(lat);
      chk("pat_message", 32'(message), 32'(exp_msg));
      do_start;
      stream(1, 2, 3);
      wait_done(lat);
      chk("gap_message", 32'(message), 32'(exp_msg));
      chk("gap_latency", lat, 65);

      // reset taken in place of MAC 30
      set_identity;
      do_start;
      stream(0, 0, 0);
      while (cyc < last_cap + 29) tick;
      reset = 1;
      tick;
      run_valid = 0; held_msg = '0; cur_msg = '0; exp_busy = 0;
      reset = 0;
      chk("midrst_msg_ready", 32'(msg_ready), 0);
      chk("midrst_message", 32'(message), 0);
      chk("midrst_busy", 32'(busy), 0);
      do_start;
      stream(0, 0, 0);
      wait_done(lat);
      chk("after_rst_message", 32'(message), 32'h65);

      // start pulse during MULT leaves the run untouched
      set_pattern;
      do_start;
      stream(0, 0, 0);
      while (cyc < last_cap + 10) tick;
      start = 1;
      tick;
      start = 0;
      chk("mult_start_busy", 32'(busy), 1);
      chk("mult_start_msg_ready", 32'(msg_ready), 0);
      wait_done(lat);
      chk("mult_start_message", 32'(message), 32'(exp_msg));
      chk("mult_start_latency", lat, 65);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
